// File: rtl/trdb_stage_sequencer_if.sv
// trdb_stage_sequencer_if: core-side handshake and lc/tc/nc stage outputs of the trace stage sequencer
interface trdb_stage_sequencer_if #(
    parameter int XLEN = 32
);
    logic            trace_enable_i;
    logic            inst_valid_i;
    logic            ready_o;
    logic            stall_i;
    logic [XLEN-1:0] iaddr_i;
    logic [XLEN-1:0] insn_i;
    logic            compressed_i;
    logic            exception_i;
    logic            lc_valid_o;
    logic            tc_valid_o;
    logic            nc_valid_o;
    logic [XLEN-1:0] lc_iaddr_o;
    logic [XLEN-1:0] tc_iaddr_o;
    logic [XLEN-1:0] nc_iaddr_o;
    logic [XLEN-1:0] tc_insn_o;
    logic [XLEN-1:0] nc_insn_o;
    logic            tc_compressed_o;
    logic            nc_compressed_o;
    logic            lc_exception_o;
    logic            tc_exception_o;
    logic            nc_exception_o;
    logic            tc_first_qualified_o;
    logic            tc_last_o;
    logic            busy_o;
    modport master (
        output trace_enable_i, inst_valid_i, stall_i, iaddr_i, insn_i, compressed_i, exception_i,
        input  ready_o, lc_valid_o, tc_valid_o, nc_valid_o, lc_iaddr_o, tc_iaddr_o, nc_iaddr_o,
               tc_insn_o, nc_insn_o, tc_compressed_o, nc_compressed_o, lc_exception_o,
               tc_exception_o, nc_exception_o, tc_first_qualified_o, tc_last_o, busy_o
    );
    modport slave (
        input  trace_enable_i, inst_valid_i, stall_i, iaddr_i, insn_i, compressed_i, exception_i,
        output ready_o, lc_valid_o, tc_valid_o, nc_valid_o, lc_iaddr_o, tc_iaddr_o, nc_iaddr_o,
               tc_insn_o, nc_insn_o, tc_compressed_o, nc_compressed_o, lc_exception_o,
               tc_exception_o, nc_exception_o, tc_first_qualified_o, tc_last_o, busy_o
    );
endinterface

// File: rtl/trdb_stage_sequencer.sv
// trdb_stage_sequencer: aligns retired instructions into lc/tc/nc stages under a fill/run/drain tracing FSM
module trdb_stage_sequencer #(
    parameter int XLEN = 32
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    trdb_stage_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] iaddr;
        logic [XLEN-1:0] insn;
        logic            compressed;
        logic            exception;
        logic            first;
    } stage_t;
    state_t          state_q, state_d;
    stage_t          tc_q, nc_q, nc_in;
    logic            lc_valid_q, lc_exception_q;
    logic [XLEN-1:0] lc_iaddr_q;
    logic            got_first_q;
    logic            ready, accept, advance, tc_last;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    // DRAIN ends once nothing remains behind tc, i.e. the last instruction is consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.trace_enable_i ? FILL : IDLE;
            FILL:    state_d = !bus.trace_enable_i
                               ? ((lc_valid_q || tc_q.valid || nc_q.valid || accept) ? DRAIN : IDLE)
                               : ((accept && nc_q.valid) ? RUN : FILL);
            RUN:     state_d = bus.trace_enable_i ? RUN : DRAIN;
            DRAIN:   state_d = (!bus.stall_i && !nc_q.valid) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        ready   = !bus.stall_i && (state_q == FILL || state_q == RUN);
        accept  = bus.inst_valid_i && ready;
        advance = accept || (state_q == DRAIN && !bus.stall_i && (tc_q.valid || nc_q.valid));
        tc_last = state_q == DRAIN && tc_q.valid && !nc_q.valid;
        nc_in   = accept ? {1'b1, bus.iaddr_i, bus.insn_i, bus.compressed_i, bus.exception_i, !got_first_q}
                         : '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            lc_valid_q     <= 1'b0;
            lc_iaddr_q     <= '0;
            lc_exception_q <= 1'b0;
            tc_q           <= '0;
            nc_q           <= '0;
            got_first_q    <= 1'b0;
        end else begin
            got_first_q <= state_q == IDLE ? 1'b0 : got_first_q || accept;
            if (advance) begin
                lc_valid_q     <= tc_q.valid;
                lc_iaddr_q     <= tc_q.iaddr;
                lc_exception_q <= tc_q.exception;
                tc_q           <= nc_q;
                nc_q           <= nc_in;
            end
        end
    assign bus.ready_o              = ready;
    assign bus.busy_o               = state_q != IDLE;
    assign bus.tc_last_o            = tc_last;
    assign bus.lc_valid_o           = lc_valid_q;
    assign bus.lc_iaddr_o           = lc_iaddr_q;
    assign bus.lc_exception_o       = lc_exception_q;
    assign bus.tc_valid_o           = tc_q.valid;
    assign bus.tc_iaddr_o           = tc_q.iaddr;
    assign bus.tc_insn_o            = tc_q.insn;
    assign bus.tc_compressed_o      = tc_q.compressed;
    assign bus.tc_exception_o       = tc_q.exception;
    assign bus.tc_first_qualified_o = tc_q.first;
    assign bus.nc_valid_o           = nc_q.valid;
    assign bus.nc_iaddr_o           = nc_q.iaddr;
    assign bus.nc_insn_o            = nc_q.insn;
    assign bus.nc_compressed_o      = nc_q.compressed;
    assign bus.nc_exception_o       = nc_q.exception;
endmodule
